// File: rtl/master_speed_pkg.sv
// Shared types and width helpers for the speed-control FSM and its button front end.
// Helpers keep every derived width at least one bit for degenerate parameter choices.
package master_speed_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } rpt_state_t;

    function automatic int unsigned level_width(input int unsigned max_shift);
        return (2 * max_shift + 1 > 1) ? $clog2(2 * max_shift + 1) : 1;
    endfunction

    function automatic int unsigned channel_width(input int unsigned num_channels);
        return (num_channels > 1) ? $clog2(num_channels) : 1;
    endfunction

    function automatic int unsigned count_width(input int unsigned delay, input int unsigned period);
        int unsigned m;
        m = (delay > period) ? delay : period;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

    // The x1 speed sits in the middle of the 0..2*MAX_SHIFT level range.
    function automatic int unsigned level_centre(input int unsigned max_shift);
        return max_shift;
    endfunction

endpackage

// File: rtl/master_speed_fsm_button_repeat.sv
// Edge detection for next/faster/slower plus the DELAY/REPEAT auto-repeat counter.
// Emits a one-cycle step pulse with its direction, and a one-cycle next pulse.
module button_repeat
    import master_speed_pkg::*;
#(
    parameter int unsigned REPEAT_DELAY  = 8,
    parameter int unsigned REPEAT_PERIOD = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic i_next,
    input  logic i_faster,
    input  logic i_slower,
    output logic o_next_pulse,
    output logic o_step,
    output logic o_dir
);

    localparam int unsigned CNT_W = count_width(REPEAT_DELAY, REPEAT_PERIOD);
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

    logic             r_prev_next;
    logic             r_prev_faster;
    logic             r_prev_slower;
    logic             r_hold_off;
    rpt_state_t       r_state;
    rpt_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;
    logic             w_next_rise;
    logic             w_single;
    logic             w_press;
    logic             w_step;

    // r_hold_off masks a button still held through reset (history clears to 0,
    // which would otherwise look like a fresh edge); it drops once both are released.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_prev_next   <= 1'b0;
            r_prev_faster <= 1'b0;
            r_prev_slower <= 1'b0;
            r_hold_off    <= 1'b1;
            r_state       <= ST_IDLE;
            r_count       <= '0;
        end else begin
            r_prev_next   <= i_next;
            r_prev_faster <= i_faster;
            r_prev_slower <= i_slower;
            r_hold_off    <= r_hold_off & (i_faster | i_slower);
            r_state       <= w_state_nxt;
            r_count       <= w_count_nxt;
        end
    end

    assign w_next_rise = i_next & ~r_prev_next;
    assign w_single    = i_faster ^ i_slower;
    assign w_press     = w_single & ~r_hold_off &
                         ((i_faster & ~r_prev_faster) | (i_slower & ~r_prev_slower));

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_step      = 1'b0;
        if (w_next_rise || !w_single) begin
            w_state_nxt = ST_IDLE;
            w_count_nxt = '0;
        end else if (w_press) begin
            w_state_nxt = ST_DELAY;
            w_count_nxt = '0;
            w_step      = 1'b1;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    w_count_nxt = '0;
                end
                ST_DELAY: begin
                    if (r_count == DELAY_LAST) begin
                        w_state_nxt = ST_REPEAT;
                        w_count_nxt = '0;
                        w_step      = 1'b1;
                    end else begin
                        w_count_nxt = r_count + 1'b1;
                    end
                end
                ST_REPEAT: begin
                    if (r_count == PERIOD_LAST) begin
                        w_count_nxt = '0;
                        w_step      = 1'b1;
                    end else begin
                        w_count_nxt = r_count + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_count_nxt = '0;
                end
            endcase
        end
    end

    assign o_next_pulse = w_next_rise;
    assign o_step       = w_step;
    assign o_dir        = i_faster;

endmodule

// File: rtl/master_speed_fsm.sv
// Multi-channel speed level register file with one-hot shift decode.
// Steps and channel changes come from the button_repeat front end.
module master_speed_fsm
    import master_speed_pkg::*;
#(
    parameter int unsigned MAX_SHIFT     = 2,
    parameter int unsigned NUM_CHANNELS  = 2,
    parameter int unsigned REPEAT_DELAY  = 8,
    parameter int unsigned REPEAT_PERIOD = 4,
    parameter int unsigned WRAP          = 0
) (
    input  logic                                    clock,
    input  logic                                    reset,
    input  logic                                    next,
    input  logic                                    slower,
    input  logic                                    faster,
    output logic [channel_width(NUM_CHANNELS)-1:0]  channel,
    output logic [level_width(MAX_SHIFT)-1:0]       level,
    output logic [MAX_SHIFT-1:0]                    shift_left,
    output logic [MAX_SHIFT-1:0]                    shift_right,
    output logic                                    at_max,
    output logic                                    at_min
);

    localparam int unsigned LW           = level_width(MAX_SHIFT);
    localparam int unsigned CW           = channel_width(NUM_CHANNELS);
    localparam int unsigned LEVEL_CENTRE = level_centre(MAX_SHIFT);
    localparam logic [LW-1:0] LEVEL_MAX  = LW'(2 * MAX_SHIFT);
    localparam logic [LW-1:0] LEVEL_MID  = LW'(LEVEL_CENTRE);
    localparam logic [CW-1:0] CHAN_LAST  = CW'(NUM_CHANNELS - 1);

    logic [LW-1:0] r_level [NUM_CHANNELS];
    logic [CW-1:0] r_channel;
    logic [LW-1:0] w_cur;
    logic [LW-1:0] w_level_nxt;
    logic          w_next_pulse;
    logic          w_step;
    logic          w_dir;

    button_repeat #(
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_button_repeat (
        .clock       (clock),
        .reset       (reset),
        .i_next      (next),
        .i_faster    (faster),
        .i_slower    (slower),
        .o_next_pulse(w_next_pulse),
        .o_step      (w_step),
        .o_dir       (w_dir)
    );

    assign w_cur = r_level[r_channel];

    always_comb begin
        w_level_nxt = w_cur;
        if (w_dir) begin
            if (w_cur == LEVEL_MAX)
                w_level_nxt = (WRAP != 0) ? '0 : w_cur;
            else
                w_level_nxt = w_cur + 1'b1;
        end else begin
            if (w_cur == '0)
                w_level_nxt = (WRAP != 0) ? LEVEL_MAX : w_cur;
            else
                w_level_nxt = w_cur - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_CHANNELS; i++)
                r_level[i] <= LEVEL_MID;
            r_channel <= '0;
        end else if (w_next_pulse) begin
            r_channel <= (r_channel == CHAN_LAST) ? '0 : r_channel + 1'b1;
        end else if (w_step) begin
            r_level[r_channel] <= w_level_nxt;
        end
    end

    // Bit k of each one-hot vector marks a distance of k+1 from the centre level.
    always_comb begin
        shift_left  = '0;
        shift_right = '0;
        for (int unsigned k = 0; k < MAX_SHIFT; k++) begin
            shift_left[k]  = (w_cur == LW'(LEVEL_CENTRE + 1 + k));
            shift_right[k] = (w_cur == LW'(LEVEL_CENTRE - 1 - k));
        end
    end

    assign channel = r_channel;
    assign level   = w_cur;
    assign at_max  = (w_cur == LEVEL_MAX);
    assign at_min  = (w_cur == '0);

endmodule

// File: tb/tb_master_speed_fsm.sv
// Directed bench for master_speed_fsm: default (saturating) instance plus a WRAP=1 instance.
module tb_master_speed_fsm;

    logic       clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset, next, slower, faster;
    logic [0:0] channel;
    logic [2:0] level;
    logic [1:0] shift_left, shift_right;
    logic       at_max, at_min;

    logic       rw_reset, rw_next, rw_slower, rw_faster;
    logic [0:0] rw_channel;
    logic [2:0] rw_level;
    logic [1:0] rw_shift_left, rw_shift_right;
    logic       rw_at_max, rw_at_min;

    int errors = 0;
    int checks = 0;

    // Expected decode for levels 0..4 with MAX_SHIFT=2.
    logic [1:0] exp_sl [5] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b10};
    logic [1:0] exp_sr [5] = '{2'b10, 2'b01, 2'b00, 2'b00, 2'b00};

    master_speed_fsm dut (
        .clock      (clock),
        .reset      (reset),
        .next       (next),
        .slower     (slower),
        .faster     (faster),
        .channel    (channel),
        .level      (level),
        .shift_left (shift_left),
        .shift_right(shift_right),
        .at_max     (at_max),
        .at_min     (at_min)
    );

    master_speed_fsm #(.WRAP(1)) dut_wrap (
        .clock      (clock),
        .reset      (rw_reset),
        .next       (rw_next),
        .slower     (rw_slower),
        .faster     (rw_faster),
        .channel    (rw_channel),
        .level      (rw_level),
        .shift_left (rw_shift_left),
        .shift_right(rw_shift_right),
        .at_max     (rw_at_max),
        .at_min     (rw_at_min)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_main(input string tag, input int ch, input int lvl);
        chk({tag, ".channel"}, 32'(channel), 32'(ch));
        chk({tag, ".level"}, 32'(level), 32'(lvl));
        chk({tag, ".shift_left"}, 32'(shift_left), 32'(exp_sl[lvl]));
        chk({tag, ".shift_right"}, 32'(shift_right), 32'(exp_sr[lvl]));
        chk({tag, ".at_max"}, 32'(at_max), 32'(lvl == 4));
        chk({tag, ".at_min"}, 32'(at_min), 32'(lvl == 0));
    endtask

    task automatic expect_wrap(input string tag, input int ch, input int lvl);
        chk({tag, ".channel"}, 32'(rw_channel), 32'(ch));
        chk({tag, ".level"}, 32'(rw_level), 32'(lvl));
        chk({tag, ".shift_left"}, 32'(rw_shift_left), 32'(exp_sl[lvl]));
        chk({tag, ".shift_right"}, 32'(rw_shift_right), 32'(exp_sr[lvl]));
        chk({tag, ".at_max"}, 32'(rw_at_max), 32'(lvl == 4));
        chk({tag, ".at_min"}, 32'(rw_at_min), 32'(lvl == 0));
    endtask

    initial begin
        reset = 1'b1; next = 1'b0; slower = 1'b0; faster = 1'b0;
        rw_reset = 1'b1; rw_next = 1'b0; rw_slower = 1'b0; rw_faster = 1'b0;
        tick();
        tick();
        expect_main("reset_active", 0, 2);
        reset = 1'b0;
        rw_reset = 1'b0;
        tick();
        tick();
        expect_main("reset_idle", 0, 2);
        expect_wrap("wrap_reset_idle", 0, 2);

        // Single-cycle faster pulses, saturating at the top.
        faster = 1'b1; tick(); faster = 1'b0;
        expect_main("faster1", 0, 3);
        tick();
        faster = 1'b1; tick(); faster = 1'b0;
        expect_main("faster2", 0, 4);
        tick();
        faster = 1'b1; tick(); faster = 1'b0;
        expect_main("faster_sat", 0, 4);
        tick();

        // Held slower: steps at cycles 0, 8, 12, 16, then holds at 0.
        slower = 1'b1;
        for (int c = 0; c < 20; c++) begin
            int e;
            tick();
            e = (c < 8) ? 3 : (c < 12) ? 2 : (c < 16) ? 1 : 0;
            chk($sformatf("slower_hold.c%0d", c), 32'(level), 32'(e));
            if (c == 16 || c == 19)
                expect_main($sformatf("slower_hold_min.c%0d", c), 0, 0);
        end
        slower = 1'b0;
        tick();

        // Raise ch0 back to 4, then check per-channel storage across next.
        for (int i = 0; i < 4; i++) begin
            faster = 1'b1; tick(); faster = 1'b0; tick();
        end
        expect_main("ch0_at_4", 0, 4);
        next = 1'b1; tick(); next = 1'b0;
        expect_main("next_to_ch1", 1, 2);
        tick();
        faster = 1'b1; tick(); faster = 1'b0;
        expect_main("ch1_faster", 1, 3);
        tick();
        next = 1'b1; tick(); next = 1'b0;
        expect_main("next_to_ch0", 0, 4);
        tick();

        // Both step buttons together: no step, no repeat while held.
        faster = 1'b1; slower = 1'b1; tick();
        expect_main("both_rise", 0, 4);
        for (int i = 0; i < 12; i++) tick();
        expect_main("both_held", 0, 4);
        faster = 1'b0; slower = 1'b0; tick();

        // next with faster in the same cycle: channel moves, step dropped, no repeat after.
        next = 1'b1; faster = 1'b1; tick(); next = 1'b0;
        expect_main("next_and_faster", 1, 3);
        for (int i = 0; i < 12; i++) tick();
        expect_main("faster_held_after_next", 1, 3);
        faster = 1'b0; tick();

        // Direct faster->slower switch restarts DELAY with one step.
        faster = 1'b1; tick();
        expect_main("switch_pre", 1, 4);
        faster = 1'b0; slower = 1'b1; tick();
        expect_main("switch_step", 1, 3);
        for (int i = 0; i < 7; i++) tick();
        chk("switch_delay_c7", 32'(level), 32'd3);
        tick();
        chk("switch_delay_c8", 32'(level), 32'd2);
        slower = 1'b0; tick();

        // WRAP=1 instance: top wraps to 0, bottom wraps to max.
        rw_faster = 1'b1; tick(); rw_faster = 1'b0; tick();
        rw_faster = 1'b1; tick(); rw_faster = 1'b0;
        expect_wrap("wrap_up_to_4", 0, 4);
        tick();
        rw_faster = 1'b1; tick(); rw_faster = 1'b0;
        expect_wrap("wrap_max_to_0", 0, 0);
        tick();
        rw_slower = 1'b1; tick(); rw_slower = 1'b0;
        expect_wrap("wrap_0_to_max", 0, 4);
        tick();

        // Reset while slower is held: restores centre and needs a release/re-press.
        rw_slower = 1'b1; tick();
        chk("wrap_hold_step", 32'(rw_level), 32'd3);
        tick(); tick();
        rw_reset = 1'b1; tick();
        expect_wrap("wrap_reset_mid_repeat", 0, 2);
        rw_reset = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        expect_wrap("wrap_held_after_reset", 0, 2);
        rw_slower = 1'b0; tick();
        chk("wrap_released", 32'(rw_level), 32'd2);
        rw_slower = 1'b1; tick(); rw_slower = 1'b0;
        expect_wrap("wrap_repress", 0, 1);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/master_speed_fsm.md
Name: master_speed_fsm

Overview:
Parametrised speed-control state machine for the playback/display datapath. Turns faster/slower/next button levels into a per-channel speed level. Decodes that level into one-hot left/right shift controls for the downstream shifter. Generalises the fixed 5-state speed FSM with multiple channels, edge detection, auto-repeat on held buttons, and a saturate/wrap mode.

Parameters:
MAX_SHIFT, 2, max shift magnitude; levels 0..2*MAX_SHIFT, centre (x1 speed) = MAX_SHIFT
NUM_CHANNELS, 2, independent speed registers; next selects among them
REPEAT_DELAY, 8, cycles a step button must stay high before auto-repeat starts
REPEAT_PERIOD, 4, cycles between auto-repeat steps
WRAP, 0, 0 = saturate at ends; 1 = wrap max->0 and 0->max

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
next  input  1  level; rising edge selects next channel
slower  input  1  level; rising edge / repeat decrements level of selected channel
faster  input  1  level; rising edge / repeat increments level of selected channel
channel  output  clog2(NUM_CHANNELS) (min 1)  currently selected channel
level  output  clog2(2*MAX_SHIFT+1)  speed level of selected channel
shift_left  output  MAX_SHIFT  one-hot; bit k = shift left by k+1 (faster)
shift_right  output  MAX_SHIFT  one-hot; bit k = shift right by k+1 (slower)
at_max  output  1  level == 2*MAX_SHIFT
at_min  output  1  level == 0

Behaviour:
- Reset (sync, active-high, all registers) gives the following state:
  - every channel level = MAX_SHIFT; channel = 0; shift_left = shift_right = 0; at_max = at_min = 0.
  - edge-detect history cleared to 0; repeat FSM in IDLE.
- Edge detect: registers prev_next, prev_slower, prev_faster. A rising edge is input=1 while prev=0, sampled at posedge.
- Latency: the step takes effect at the posedge where the rising edge is sampled. Outputs reflect it in the following cycle.
- Decode from the level register:
  - d = level - MAX_SHIFT.
  - d > 0: shift_left bit d-1 set. d < 0: shift_right bit -d-1 set. d = 0: both zero.
  - Never both non-zero.
- Step rules:
  - faster: level+1. slower: level-1.
  - WRAP=0: saturates; stepping at an end is a no-op.
  - WRAP=1: modulo 2*MAX_SHIFT+1.
- Priority when events coincide in one cycle:
  - next edge wins; any step in that cycle is dropped.
  - faster and slower both high: no step, repeat FSM forced to IDLE.
- next: channel = channel+1, wrapping to 0 after NUM_CHANNELS-1. The new channel's stored level appears on outputs the next cycle. Other channels keep their levels.
- Repeat FSM, driven by "single step button held" (exactly one of faster/slower high):
  - IDLE -> DELAY on rising edge; that edge causes one step; counter cleared.
  - DELAY: counter increments each cycle. When counter == REPEAT_DELAY-1 -> REPEAT, one step, counter cleared.
  - REPEAT: counter increments each cycle; step when counter == REPEAT_PERIOD-1, then counter clears.
  - Any state -> IDLE when the button is released, both buttons are high, or a next edge occurs.
  - Switching directly from faster to slower (one falls, the other rises in the same cycle) counts as release plus a new rising edge: return to DELAY and take one step.
- Counter width: clog2(max(REPEAT_DELAY, REPEAT_PERIOD)). No overflow is possible given the compare-and-clear.
- Reset mid-repeat: everything is restored to the reset state in that cycle. The held button must be released and re-pressed to step again.

Decomposition:
- Package master_speed_pkg holds:
  - repeat FSM state enum (IDLE, DELAY, REPEAT);
  - width helper functions (level width, channel width);
  - LEVEL_CENTRE constant derivation.
- One natural sub-module, button_repeat, containing the edge detect plus the DELAY/REPEAT counter FSM. It emits a single-cycle step pulse and a direction bit. The top module holds the channel/level register file and the decode.

Test Plan:
All scenarios use the default parameters.
1. Reset then idle -> channel=0, level=2, shift_left=00, shift_right=00, at_min=at_max=0.
2. faster pulsed high 1 cycle, twice -> level 3 (shift_left=01), then 4 (shift_left=10, at_max=1). A third pulse leaves level=4 (saturate).
3. slower held 20 cycles from level 4:
   - steps at cycle 0 (level 3) and cycle 8 (level 2);
   - then every 4 cycles (cycles 12, 16) -> levels 1, 0, where shift_right=10 and at_min=1;
   - level holds at 0 thereafter.
4. Set ch0 to 4. Pulse next -> channel=1, level=2. faster -> ch1 level 3. next -> channel=0, level=4 (ch0 retained).
5. faster and slower rising in the same cycle -> no level change, FSM IDLE. next and faster rising together -> channel increments, no level step.
6. WRAP=1 build: from level 4, faster pulse -> level 0. Then assert reset while slower is held -> level=2, channel=0, and no step until slower is released and re-pressed.
